// File: rtl/enc4to2_event_if.sv
// ---------------------------------------------------------------------------
// enc4to2_event_if
//   Valid/ready output channel of the sequential 4-to-2 event encoder.
//
//   Signals:
//     out_valid  producer -> consumer  code is valid this cycle
//     out_ready  consumer -> producer  consumer accepts code this cycle
//     code[1:0]  producer -> consumer  encoded index of the served request
//
//   Modports:
//     master  the encoder (drives out_valid/code, observes out_ready)
//     slave   the consumer (drives out_ready, observes out_valid/code)
// ---------------------------------------------------------------------------
interface enc4to2_event_if;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] code;

  modport master (
    output out_valid,
    output code,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  code,
    output out_ready
  );
endinterface

// File: rtl/enc4to2_event.sv
// ---------------------------------------------------------------------------
// enc4to2_event
//   Sequential 4-to-2 encoder. Four asynchronous request lines are
//   synchronized, each rising edge is captured as a pending event, and
//   pending events are drained one per transfer as a 2-bit code over a
//   valid/ready channel in a fixed priority order.
//
//   Parameters:
//     SYNC_STAGES  synchronizer flops per input bit (2..4)
//     HIGH_FIRST   1: bit 3 served first, 0: bit 0 served first
//
//   Ports:
//     clk          single clock, rising edge
//     rst_n        asynchronous active-low reset
//     d[3:0]       asynchronous request lines
//     E            capture enable (0 blocks new events, draining continues)
//     clr_ovf      synchronous clear of the overflow flag
//     any_pending  OR of the pending register
//     overflow     sticky: an event arrived on a bit that was still pending
//     bus          output channel (out_valid, out_ready, code)
// ---------------------------------------------------------------------------
module enc4to2_event #(
  parameter int SYNC_STAGES = 2,
  parameter bit HIGH_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             d,
  input  logic                   E,
  input  logic                   clr_ovf,
  output logic                   any_pending,
  output logic                   overflow,
  enc4to2_event_if.master        bus
);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] s;
  logic [3:0] prev;
  logic [3:0] rise;
  logic [3:0] pending;
  logic [3:0] clr_mask;
  logic [3:0] pending_next;
  logic [1:0] sel_idx;
  logic       load;
  logic       ovf_set;

  // NOTE: the synchronizer chain is reset along with the rest of the state so
  // that a line held high across reset release yields exactly one rise event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;

  // Output stage is free when empty or being drained this cycle. Only the
  // registered pending value is considered; a same-cycle rise waits a cycle.
  assign load = (~bus.out_valid | bus.out_ready) & (|pending);

  // NOTE: every always_comb output gets a default first so no latch is
  // inferred when no pending bit is set.
  always_comb begin
    sel_idx = '0;
    if (HIGH_FIRST) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < 4; i++) begin
        if (pending[i]) sel_idx = 2'(i);
      end
    end else begin
      // Descending scan: the last hit is the lowest set bit.
      for (int i = 3; i >= 0; i--) begin
        if (pending[i]) sel_idx = 2'(i);
      end
    end
  end

  assign clr_mask = load ? (4'b0001 << sel_idx) : 4'b0000;

  // A rise on a bit being served this cycle re-arms it instead of being lost,
  // so only bits that stay pending can overflow.
  assign pending_next = E ? ((pending & ~clr_mask) | rise) : (pending & ~clr_mask);
  assign ovf_set      = E & (|(rise & pending & ~clr_mask));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev          <= '0;
      pending       <= '0;
      overflow      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.code      <= '0;
    end else begin
      prev     <= s;
      pending  <= pending_next;
      // Set has priority over a same-cycle clear.
      overflow <= ovf_set | (overflow & ~clr_ovf);
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.code      <= sel_idx;
      end else if (bus.out_ready) begin
        // Accepted with nothing left to send; code keeps its last value.
        bus.out_valid <= 1'b0;
      end
    end
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_enc4to2_event.sv
// ---------------------------------------------------------------------------
// tb_enc4to2_event
//   Two encoder instances share all stimulus: dut_a with HIGH_FIRST=1 and
//   dut_b with HIGH_FIRST=0. Expected codes are queued per instance when a
//   request edge is driven and popped by a monitor on each accepted transfer.
//   Directed cycle-exact checks cover latency, backpressure, overflow,
//   enable gating and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_enc4to2_event;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic       E;
  logic       clr_ovf;
  logic       out_ready;
  logic       any_pending_a, any_pending_b;
  logic       overflow_a, overflow_b;

  int checks = 0;
  int errors = 0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] exp_a, exp_b;

  enc4to2_event_if bus_a ();
  enc4to2_event_if bus_b ();

  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  enc4to2_event #(.SYNC_STAGES(2), .HIGH_FIRST(1'b1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .E           (E),
    .clr_ovf     (clr_ovf),
    .any_pending (any_pending_a),
    .overflow    (overflow_a),
    .bus         (bus_a)
  );

  enc4to2_event #(.SYNC_STAGES(2), .HIGH_FIRST(1'b0)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .E           (E),
    .clr_ovf     (clr_ovf),
    .any_pending (any_pending_b),
    .overflow    (overflow_b),
    .bus         (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [1:0] ca, input logic [1:0] cb);
    qa.push_back(ca);
    qb.push_back(cb);
  endtask

  // Scoreboard: each accepted transfer must match the oldest queued code.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_a.out_valid === 1'b1 && out_ready === 1'b1) begin
        check("a_transfer_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          exp_a = qa.pop_front();
          check("a_code", 32'(bus_a.code), 32'(exp_a));
        end
      end
      if (bus_b.out_valid === 1'b1 && out_ready === 1'b1) begin
        check("b_transfer_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          exp_b = qb.pop_front();
          check("b_code", 32'(bus_b.code), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    d         = 4'b0000;
    E         = 1'b1;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_valid",    32'(bus_a.out_valid), 32'd0);
    check("rst_code",     32'(bus_a.code),      32'd0);
    check("rst_pending",  32'(any_pending_a),   32'd0);
    check("rst_overflow", 32'(overflow_a),      32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single event latency: d[2] sampled at edge N
    d = 4'b0100;
    push_both(2'd2, 2'd2);
    tick(1);                                   // N
    check("lat_pend_n",   32'(any_pending_a),   32'd0);
    tick(1);                                   // N+1
    check("lat_pend_n1",  32'(any_pending_a),   32'd0);
    check("lat_valid_n1", 32'(bus_a.out_valid), 32'd0);
    tick(1);                                   // N+2
    check("lat_pend_n2",  32'(any_pending_a),   32'd1);
    check("lat_valid_n2", 32'(bus_a.out_valid), 32'd0);
    tick(1);                                   // N+3
    check("lat_valid_n3", 32'(bus_a.out_valid), 32'd1);
    check("lat_code_n3",  32'(bus_a.code),      32'd2);
    check("lat_pend_n3",  32'(any_pending_a),   32'd0);
    tick(1);                                   // N+4
    check("lat_valid_n4", 32'(bus_a.out_valid), 32'd0);
    d = 4'b0000;
    tick(4);

    // Simultaneous events 3 and 0, both priority orders
    d = 4'b1001;
    push_both(2'd3, 2'd0);
    push_both(2'd0, 2'd3);
    tick(4);                                   // N+3
    check("prio_a_first",  32'(bus_a.code), 32'd3);
    check("prio_b_first",  32'(bus_b.code), 32'd0);
    check("prio_a_valid1", 32'(bus_a.out_valid), 32'd1);
    tick(1);                                   // N+4
    check("prio_a_second", 32'(bus_a.code), 32'd0);
    check("prio_b_second", 32'(bus_b.code), 32'd3);
    check("prio_a_valid2", 32'(bus_a.out_valid), 32'd1);
    tick(1);                                   // N+5
    check("prio_a_idle",   32'(bus_a.out_valid), 32'd0);
    check("prio_b_idle",   32'(bus_b.out_valid), 32'd0);
    d = 4'b0000;
    tick(4);

    // Backpressure
    out_ready = 1'b0;
    d = 4'b0010;
    push_both(2'd1, 2'd1);
    tick(4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp_hold_code",  32'(bus_a.code),      32'd1);
      tick(1);
    end
    d = 4'b1010;
    push_both(2'd3, 2'd3);
    tick(5);
    check("bp_code_stays", 32'(bus_a.code),    32'd1);
    check("bp_pending",    32'(any_pending_a), 32'd1);
    check("bp_b_code",     32'(bus_b.code),    32'd1);
    out_ready = 1'b1;
    tick(1);
    check("bp_next_code",  32'(bus_a.code),      32'd3);
    check("bp_next_valid", 32'(bus_a.out_valid), 32'd1);
    tick(1);
    check("bp_drained",    32'(bus_a.out_valid), 32'd0);
    d = 4'b0000;
    tick(4);

    // Overflow: bit 0 loaded, then pending, then lost
    out_ready = 1'b0;
    d = 4'b0001;
    push_both(2'd0, 2'd0);
    tick(4);
    check("ovf_loaded",   32'(bus_a.code),    32'd0);
    check("ovf_pend0",    32'(any_pending_a), 32'd0);
    d = 4'b0000;
    tick(4);
    d = 4'b0001;
    push_both(2'd0, 2'd0);
    tick(4);
    check("ovf_pend1",    32'(any_pending_a), 32'd1);
    check("ovf_not_yet",  32'(overflow_a),    32'd0);
    d = 4'b0000;
    tick(4);
    d = 4'b0001;
    tick(4);
    check("ovf_set_a",    32'(overflow_a),    32'd1);
    check("ovf_set_b",    32'(overflow_b),    32'd1);
    d = 4'b0000;
    tick(2);
    check("ovf_sticky",   32'(overflow_a),    32'd1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_cleared",  32'(overflow_a),    32'd0);
    out_ready = 1'b1;
    tick(3);
    check("ovf_drain_valid", 32'(bus_a.out_valid), 32'd0);
    check("ovf_drain_pend",  32'(any_pending_a),   32'd0);
    tick(2);

    // Enable gating
    E = 1'b0;
    d = 4'b0100;
    tick(4);
    check("en_off_valid", 32'(bus_a.out_valid), 32'd0);
    check("en_off_pend",  32'(any_pending_a),   32'd0);
    d = 4'b0000;
    tick(4);
    d = 4'b0100;
    tick(4);
    E = 1'b1;
    tick(5);
    check("en_held_valid", 32'(bus_a.out_valid), 32'd0);
    check("en_held_pend",  32'(any_pending_a),   32'd0);
    d = 4'b0000;
    tick(4);
    d = 4'b0100;
    push_both(2'd2, 2'd2);
    tick(4);
    check("en_rearm_valid", 32'(bus_a.out_valid), 32'd1);
    check("en_rearm_code",  32'(bus_a.code),      32'd2);
    d = 4'b0000;
    tick(4);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    d = 4'b0010;
    push_both(2'd1, 2'd1);
    tick(4);
    d = 4'b0000;
    tick(4);
    d = 4'b0010;
    tick(4);
    d = 4'b0000;
    tick(4);
    d = 4'b0010;
    tick(4);
    check("pre_rst_valid", 32'(bus_a.out_valid), 32'd1);
    check("pre_rst_pend",  32'(any_pending_a),   32'd1);
    check("pre_rst_ovf",   32'(overflow_a),      32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_now_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_now_pend",  32'(any_pending_a),   32'd0);
    check("rst_now_ovf",   32'(overflow_a),      32'd0);
    check("rst_now_b",     32'(bus_b.out_valid), 32'd0);
    qa.delete();
    qb.delete();
    tick(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push_both(2'd1, 2'd1);
    tick(10);
    check("post_rst_idle", 32'(bus_a.out_valid), 32'd0);
    check("qa_empty", 32'(qa.size()), 32'd0);
    check("qb_empty", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc4to2_event.md
Name: enc4to2_event

Overview:
- Sequential 4-to-2 encoder; the inverse of the existing 2-to-4 decoder.
- Watches four asynchronous request lines and synchronizes them.
- Captures each rising edge as a pending event.
- Drains pending events one at a time as a 2-bit code over a valid/ready handshake, with a selectable priority order.
- Sits between raw request/keypad lines and downstream control logic that consumes one encoded event per transfer.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input bit (legal 2..4).
- HIGH_FIRST, 1, 1 = bit 3 has highest priority, 0 = bit 0 has highest priority.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  4  asynchronous request lines, one per code.
- E  input  1  capture enable; 0 blocks new event capture.
- out_ready  input  1  consumer accepts code this cycle.
- clr_ovf  input  1  synchronous clear of overflow flag.
- out_valid  output  1  code is valid.
- code  output  2  encoded index of the served request.
- any_pending  output  1  OR of the pending register.
- overflow  output  1  sticky flag: an event was lost.

Behaviour:
- Reset (rst_n=0, async):
  - Synchronizer chain, prev register, pending[3:0], out_valid, code, overflow all go to 0.
  - any_pending reads 0.
  - Takes effect immediately, mid-transfer included; any event in flight is discarded.
- Synchronizer: d passes through SYNC_STAGES flops to produce s[3:0].
- Edge detect:
  - prev <= s every cycle.
  - rise = s & ~prev (combinational).
  - A line held high across reset release produces one rise event, because s and prev both reset to 0.
- Event capture:
  - When E=1: pending <= (pending & ~clr_mask) | rise.
  - When E=0: rise is ignored; pending still clears served bits.
  - E does not affect draining.
- Overflow:
  - If E=1 and rise[i]=1 while pending[i]=1 and bit i is not being cleared this cycle, set overflow.
  - overflow stays set until clr_ovf=1.
  - If set and clear occur in the same cycle, set wins.
- Output load condition: load = (~out_valid | out_ready) & (|pending).
  - Uses the registered pending value; a same-cycle rise is not visible.
- On load:
  - code <= index of the highest-priority set bit of pending, per HIGH_FIRST.
  - out_valid <= 1.
  - clr_mask = one-hot of that index; that bit is cleared next edge.
- On out_valid & out_ready with no pending bits: out_valid <= 0; code holds its last value.
- Backpressure: while out_valid=1 and out_ready=0, code and out_valid are held stable.
- Throughput: with out_ready held 1, one code per cycle, back-to-back, no bubble.
- Simultaneous clear and new rise on the same bit:
  - The rise wins; the bit remains pending and is served again later.
  - No overflow is flagged.
- Latency:
  - A d[i] edge first sampled at clock edge N yields pending[i]=1 after edge N+SYNC_STAGES.
  - out_valid=1 with code=i after edge N+SYNC_STAGES+1, provided the output stage is free and no higher-priority bit is pending.
  - With defaults: 3 cycles.
- Multiple simultaneous events are served in strict priority order, one per accepted transfer.
- A lower-priority bit can starve while higher ones keep re-arming; this is intended.
- Inputs are edge-sensitive only. A held-high line produces one event; it must go low for at least one synchronized cycle to re-arm.

Test Plan:
- Defaults, E=1, out_ready=1, raise d[2] at edge N -> out_valid=1 and code=2 after edge N+3 for exactly 1 cycle; any_pending pulses for 1 cycle before that.
- d=4'b1001 rising together, out_ready=1, HIGH_FIRST=1 -> code=3 then code=0 on consecutive cycles, then out_valid=0. With HIGH_FIRST=0 -> code=0 then code=3.
- Backpressure:
  - Raise d[1] with out_ready=0 -> out_valid=1 and code=1 held for 10 cycles.
  - Then raise d[3] -> code stays 1 while any_pending=1.
  - Assert out_ready -> code=1 accepted, then code=3 on the next cycle.
- Overflow:
  - With out_ready=0 and bit0 already loaded, pulse d[0] twice (low gaps of at least 3 cycles) -> pending[0] set by the first pulse, overflow=1 after the second.
  - Pulse clr_ovf -> overflow=0 the next cycle.
- Enable gating: E=0, pulse d[2] -> no out_valid and any_pending=0; set E=1 while d[2] is held high -> still no event; drop and re-raise d[2] -> code=2.
- Reset: rst_n low mid-transfer while out_valid=1 -> out_valid, any_pending, overflow drop to 0 immediately. Release with d[1] held high -> exactly one code=1 event.
